// File: rtl/clock_reset_seq_pkg.sv
// Shared types for the clock-tree power-up sequencer: state encoding and the
// reset/status levels driven in each state.
package clock_reset_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PLL_RST  = 3'd0,
    S_WAIT_L5  = 3'd1,
    S_DIV_EN   = 3'd2,
    S_WAIT_L64 = 3'd3,
    S_SYS_REL  = 3'd4,
    S_RUN      = 3'd5,
    S_FAULT    = 3'd6
  } state_e;

  typedef struct packed {
    logic pll5x_rst;
    logic div_resetn;
    logic pll64_rst;
    logic sys_rstn;
    logic video_rstn;
    logic ready;
    logic fault;
  } rst_levels_t;

  // Output levels for a state; anything not listed keeps the fully-reset pattern.
  function automatic rst_levels_t state_levels(input state_e st);
    rst_levels_t lv;
    lv = '{pll5x_rst: 1'b1, div_resetn: 1'b0, pll64_rst: 1'b1, sys_rstn: 1'b0,
           video_rstn: 1'b0, ready: 1'b0, fault: 1'b0};
    case (st)
      S_WAIT_L5: begin
        lv.pll5x_rst = 1'b0;
      end
      S_DIV_EN: begin
        lv.pll5x_rst  = 1'b0;
        lv.div_resetn = 1'b1;
      end
      S_WAIT_L64: begin
        lv.pll5x_rst  = 1'b0;
        lv.div_resetn = 1'b1;
        lv.pll64_rst  = 1'b0;
      end
      S_SYS_REL: begin
        lv.pll5x_rst  = 1'b0;
        lv.div_resetn = 1'b1;
        lv.pll64_rst  = 1'b0;
        lv.sys_rstn   = 1'b1;
      end
      S_RUN: begin
        lv.pll5x_rst  = 1'b0;
        lv.div_resetn = 1'b1;
        lv.pll64_rst  = 1'b0;
        lv.sys_rstn   = 1'b1;
        lv.video_rstn = 1'b1;
        lv.ready      = 1'b1;
      end
      S_FAULT: begin
        lv.fault = 1'b1;
      end
      default: begin
        lv.fault = 1'b0;
      end
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/clock_reset_seq_lock_qualify.sv
// Lock qualifier: 2-FF synchronizer plus saturating count of consecutive
// synced-high cycles; qualified is registered once the count saturates.
module clock_reset_seq_lock_qualify #(
  parameter int unsigned STABLE_CYCLES = 2700
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_i,
  input  logic clr_i,
  output logic synced_o,
  output logic qualified_o
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

  logic              meta_q;
  logic              sync_q;
  logic              qual_q;
  logic              qual_d;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_d;

  // A lock reported by a PLL that is still held in reset means nothing, so clr_i restarts the count.
  always_comb begin
    stab_d = stab_q;
    qual_d = 1'b0;
    if (clr_i || !sync_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_W'(STABLE_CYCLES)) begin
      stab_d = stab_q + STAB_W'(1);
    end
    qual_d = (stab_q == STAB_W'(STABLE_CYCLES)) && !clr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      stab_q <= '0;
      qual_q <= 1'b0;
    end else begin
      meta_q <= lock_i;
      sync_q <= meta_q;
      stab_q <= stab_d;
      qual_q <= qual_d;
    end
  end

  assign synced_o    = sync_q;
  assign qualified_o = qual_q;

endmodule

// File: rtl/clock_reset_seq.sv
// Clock-tree power-up/recovery sequencer: steps PLL and divider resets in order,
// qualifies each lock, releases system then video reset, retries and faults.
module clock_reset_seq
  import clock_reset_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = 27,
  parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
  parameter int unsigned STAGE_GAP_CYCLES    = 64,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned CNT_W               = 20
) (
  input  logic               clkin,
  input  logic               resetn,
  input  logic               lock_5x_in,
  input  logic               lock_64_in,
  output logic               pll5x_rst,
  output logic               div_resetn,
  output logic               pll64_rst,
  output logic               sys_rstn,
  output logic               video_rstn,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [STATE_W-1:0] state
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic               started_q;
  logic               fail;
  rst_levels_t        lvl_q;
  rst_levels_t        lvl_d;

  logic l5_sync;
  logic l5_qual;
  logic l64_sync;
  logic l64_qual;

  clock_reset_seq_lock_qualify #(
    .STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_5x (
    .clk_i       (clkin),
    .rst_ni      (resetn),
    .lock_i      (lock_5x_in),
    .clr_i       (lvl_q.pll5x_rst),
    .synced_o    (l5_sync),
    .qualified_o (l5_qual)
  );

  clock_reset_seq_lock_qualify #(
    .STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_64 (
    .clk_i       (clkin),
    .rst_ni      (resetn),
    .lock_i      (lock_64_in),
    .clr_i       (lvl_q.pll64_rst),
    .synced_o    (l64_sync),
    .qualified_o (l64_qual)
  );

  // Next state: lock loss beats stage completion, qualification beats timeout.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      S_PLL_RST: begin
        if (started_q && (cnt_q == CNT_W'(PLL_RST_CYCLES - 1))) state_d = S_WAIT_L5;
      end
      S_WAIT_L5: begin
        if (l5_qual) state_d = S_DIV_EN;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) fail = 1'b1;
      end
      S_DIV_EN: begin
        if (!l5_sync) fail = 1'b1;
        else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) state_d = S_WAIT_L64;
      end
      S_WAIT_L64: begin
        if (!l5_sync) fail = 1'b1;
        else if (l64_qual) state_d = S_SYS_REL;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) fail = 1'b1;
      end
      S_SYS_REL: begin
        if (!l5_sync || !l64_sync) fail = 1'b1;
        else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!l5_sync || !l64_sync) fail = 1'b1;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (fail) begin
      retry_d = retry_q + RETRY_W'(1);
      state_d = (retry_d == RETRY_W'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
    end
    // The first cycle out of reset counts as the entry into S_PLL_RST.
    if (!started_q || (state_d != state_q)) cnt_d = '0;
    if ((state_d == S_RUN) && (state_q != S_RUN)) retry_d = '0;
    lvl_d = state_levels(state_d);
  end

  always_ff @(posedge clkin) begin
    if (!resetn) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      started_q <= 1'b0;
      lvl_q     <= state_levels(S_PLL_RST);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      started_q <= 1'b1;
      lvl_q     <= lvl_d;
    end
  end

  assign pll5x_rst  = lvl_q.pll5x_rst;
  assign div_resetn = lvl_q.div_resetn;
  assign pll64_rst  = lvl_q.pll64_rst;
  assign sys_rstn   = lvl_q.sys_rstn;
  assign video_rstn = lvl_q.video_rstn;
  assign ready      = lvl_q.ready;
  assign fault      = lvl_q.fault;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule
